ofmap_postproc_stream: RTL and testbench
========================================

OFMAP_POSTPROC_STREAM -- requirements
Module: ofmap_postproc_stream

Interface
REQ-001 SHALL have parameter LANES, default 8: output channels per beat (one psum per lane).
REQ-002 SHALL have parameter WD, default 8: output pixel width; psum width is 2*WD.
REQ-003 SHALL have parameter FI, default 3: output fraction bits.
REQ-004 SHALL have parameter MAXC, default 64: maximum ofmap columns; line buffer depth is MAXC/2.
REQ-005 SHALL have port clk, input, 1: the single clock; all state on rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1: one-cycle tile start; latches cfg_* when IDLE.
REQ-008 SHALL have port cfg_rows, input, 6: ofmap rows, 0..63.
REQ-009 SHALL have port cfg_cols, input, 6: ofmap columns, 0..min(63,MAXC-1).
REQ-010 SHALL have port cfg_pool, input, 1: 1 = 2x2 stride-2 max pooling.
REQ-011 SHALL have port in_valid, input, 1: psum beat valid.
REQ-012 SHALL have port in_ready, output, 1: beat accepted when in_valid && in_ready.
REQ-013 SHALL have port in_data, input, LANES*2*WD: signed psums, lane k at [2*WD*(k+1)-1 : 2*WD*k].
REQ-014 SHALL have port out_valid, output, 1: output beat valid.
REQ-015 SHALL have port out_ready, input, 1: output beat consumed when out_valid && out_ready.
REQ-016 SHALL have port out_data, output, LANES*WD: lane k at [WD*(k+1)-1 : WD*k].
REQ-017 SHALL have port busy, output, 1: high in RUN and FLUSH.
REQ-018 SHALL have port done, output, 1: one-cycle pulse at tile end.

Function
REQ-019 SHALL implement states IDLE, RUN, FLUSH, DONE; IDLE->RUN on start; RUN->FLUSH after the last input beat (rows*cols) is accepted; FLUSH->DONE when out_valid is low; DONE->IDLE unconditionally; done is high only in DONE.
REQ-020 SHALL go IDLE->DONE directly if start arrives with cfg_rows==0 or cfg_cols==0, accepting no beats.
REQ-021 SHALL ignore start outside IDLE; cfg_* changes after latch have no effect.
REQ-022 SHALL drive in_ready = (state==RUN) && (!out_valid || out_ready); in_ready is combinational from out_ready.
REQ-023 SHALL take beats in raster order: column counter 0..cols-1 wrapping into the row counter 0..rows-1.
REQ-024 SHALL compute each lane as: psum<0 -> 0; else t = psum>>FI, saturated to 2^(WD-1)-1 when t exceeds it; result is WD bits.
REQ-025 SHALL, with cfg_pool=0, register one output per accepted beat; out_valid rises the cycle after acceptance (latency 1).
REQ-026 SHALL hold out_data and out_valid stable while out_valid && !out_ready.
REQ-027 SHALL, with cfg_pool=1, hold the even-column result and take the lane-wise max with the odd-column result.
REQ-028 SHALL, on even rows, write the pair max to line buffer entry col/2.
REQ-029 SHALL, on odd rows, max the pair with line buffer entry col/2 and emit it 1 cycle after the odd-row odd-column beat.
REQ-030 SHALL, with pooling, accept but not emit the last column when cols is odd and the last row when rows is odd; rows<2 or cols<2 gives no outputs and the tile still completes.
REQ-031 SHALL, on simultaneous out_ready consumption and new-beat acceptance, load the new result with out_valid staying high.
REQ-032 SHALL need no line buffer reset; each even row writes before the odd row reads.

Reset
REQ-033 SHALL, while rst is low, force IDLE, counters to 0, out_valid=0, out_data=0, in_ready=0, busy=0, done=0.
REQ-034 SHALL abort any tile on mid-tile reset; no done pulse; the next start begins a fresh tile.

Verification
REQ-035 SHALL pass: LANES=8, WD=8, FI=3, no pool, rows=cols=2, lane0 psums 0x0028, 0xFFF0, 0x7FFF, 0x0007, out_ready=1 -> lane0 outputs 0x05, 0x00, 0x7F, 0x00; done pulses once.
REQ-036 SHALL pass: pool on, 4x4 tile, lane0 psum = 8*(r*4+c) -> outputs 5, 7, 13, 15 in order; done after the 4th output.
REQ-037 SHALL pass: pool on, rows=3, cols=5, 15 beats -> exactly 2 outputs; in_ready drops after beat 15; done pulses.
REQ-038 SHALL pass: no pool, out_ready held low 5 cycles after the first output -> out_data stable, in_ready low, no beat lost; 4 outputs total.
REQ-039 SHALL pass: start with cfg_rows=0 -> done the next cycle, in_ready never high; start pulsed during RUN -> ignored.
REQ-040 SHALL pass: rst low after 3 of 4 beats -> all outputs 0 asynchronously, no done; a new 2x2 tile then completes correctly.

Source files
------------

// File: rtl/ofmap_postproc_stream.sv
// Output-feature-map post-processing: per-lane ReLU + requantize/saturate, optional 2x2/2 max pool.
// Streams one psum beat per cycle in raster order and emits one pixel vector per output position.

module ofmap_postproc_lane #(
    parameter int WD = 8,
    parameter int FI = 3
) (
    input  logic [2*WD-1:0] psum_i,
    input  logic [WD-1:0]   hold_i,
    input  logic [WD-1:0]   lb_i,
    output logic [WD-1:0]   act_o,
    output logic [WD-1:0]   pair_o,
    output logic [WD-1:0]   pool_o
);
    localparam logic [2*WD-1:0] SAT = {{(WD+1){1'b0}}, {(WD-1){1'b1}}};

    logic [2*WD-1:0] shr;
    assign shr = psum_i >> FI;

    always_comb begin
        act_o = '0;
        if (!psum_i[2*WD-1]) act_o = (shr > SAT) ? SAT[WD-1:0] : shr[WD-1:0];
    end

    // activations are non-negative, so an unsigned compare is a valid max
    assign pair_o = (hold_i > act_o) ? hold_i : act_o;
    assign pool_o = (pair_o > lb_i)  ? pair_o : lb_i;
endmodule

module ofmap_postproc_stream #(
    parameter int LANES = 8,
    parameter int WD    = 8,
    parameter int FI    = 3,
    parameter int MAXC  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [5:0]            cfg_rows,
    input  logic [5:0]            cfg_cols,
    input  logic                  cfg_pool,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*2*WD-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*WD-1:0]   out_data,
    output logic                  busy,
    output logic                  done
);
    localparam int LBD = MAXC / 2;
    localparam int LBW = (LBD > 1) ? $clog2(LBD) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t                     state_q;
    logic [5:0]                 rows_q, cols_q, row_q, col_q;
    logic                       pool_q, busy_q, done_q;
    logic                       out_valid_q;
    logic [LANES*WD-1:0]        out_data_q;
    logic [LANES-1:0][WD-1:0]   hold_q;
    logic [LANES*WD-1:0]        lb_q [LBD];

    logic [LANES-1:0][WD-1:0]   act_w, pair_w, pool_w;
    logic [LANES*WD-1:0]        lb_rd, res_d;
    logic [LBW-1:0]             lb_idx;
    logic                       acc, last_col, last_beat, emit;

    assign in_ready  = (state_q == S_RUN) && (!out_valid_q || out_ready);
    assign acc       = in_valid && in_ready;
    assign last_col  = (col_q == cols_q - 6'd1);
    assign last_beat = last_col && (row_q == rows_q - 6'd1);
    // pooled output only completes on the odd-row, odd-column beat of each 2x2 window
    assign emit      = !pool_q || (col_q[0] && row_q[0]);
    assign lb_idx    = LBW'(col_q >> 1);
    assign lb_rd     = lb_q[lb_idx];
    assign res_d     = pool_q ? pool_w : act_w;

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign done      = done_q;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        ofmap_postproc_lane #(.WD(WD), .FI(FI)) u_lane (
            .psum_i (in_data[2*WD*k +: 2*WD]),
            .hold_i (hold_q[k]),
            .lb_i   (lb_rd[WD*k +: WD]),
            .act_o  (act_w[k]),
            .pair_o (pair_w[k]),
            .pool_o (pool_w[k])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            rows_q  <= '0;
            cols_q  <= '0;
            pool_q  <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        rows_q <= cfg_rows;
                        cols_q <= cfg_cols;
                        pool_q <= cfg_pool;
                        row_q  <= '0;
                        col_q  <= '0;
                        if (cfg_rows == 6'd0 || cfg_cols == 6'd0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (acc) begin
                        if (last_beat) begin
                            state_q <= S_FLUSH;
                            row_q   <= '0;
                            col_q   <= '0;
                        end else if (last_col) begin
                            col_q <= '0;
                            row_q <= row_q + 6'd1;
                        end else begin
                            col_q <= col_q + 6'd1;
                        end
                    end
                end
                S_FLUSH: begin
                    if (!out_valid_q) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            hold_q      <= '0;
        end else begin
            if (acc && emit) begin
                out_valid_q <= 1'b1;
                out_data_q  <= res_d;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (acc && pool_q && !col_q[0]) hold_q <= act_w;
        end
    end

    // every even row fully rewrites its entries before the odd row reads them
    always_ff @(posedge clk) begin
        if (acc && pool_q && col_q[0] && !row_q[0]) lb_q[lb_idx] <= pair_w;
    end
endmodule

// File: tb/tb_ofmap_postproc_stream.sv
// Scoreboard bench for ofmap_postproc_stream: directed tiles, monitor pops expected pixels on each handshake.

module tb_ofmap_postproc_stream;
    localparam int LANES = 8;
    localparam int WD    = 8;
    localparam int FI    = 3;
    localparam int MAXC  = 64;
    localparam int DW    = LANES*2*WD;
    localparam int OW    = LANES*WD;

    logic          clk, rst, start, cfg_pool, in_valid, in_ready, out_valid, out_ready, busy, done;
    logic [5:0]    cfg_rows, cfg_cols;
    logic [DW-1:0] in_data;
    logic [OW-1:0] out_data;

    int n_checks = 0;
    int n_err    = 0;
    int done_cnt = 0;
    int ir_cnt   = 0;
    logic [OW-1:0] sb[$];

    ofmap_postproc_stream #(.LANES(LANES), .WD(WD), .FI(FI), .MAXC(MAXC)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_rows(cfg_rows), .cfg_cols(cfg_cols),
        .cfg_pool(cfg_pool), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (in_ready) ir_cnt++;
        if (rst && out_valid && out_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_out: got unexpected %0h expected nothing", out_data);
            end else begin
                logic [OW-1:0] e;
                e = sb.pop_front();
                if (out_data !== e) begin
                    n_err++;
                    $display("FAIL sb_out: got %0h expected %0h", out_data, e);
                end
            end
        end
    end

    function automatic logic [7:0] model(input logic [15:0] p);
        logic [15:0] t;
        if (p[15]) return 8'h00;
        t = p >> FI;
        if (t > 16'd127) return 8'h7F;
        return t[7:0];
    endfunction

    function automatic logic [DW-1:0] np_beat(input logic [15:0] p0);
        logic [DW-1:0] v;
        for (int k = 0; k < LANES; k++) v[16*k +: 16] = p0 + 16'(k*24);
        return v;
    endfunction

    // lane 0 carries the hand-computed value; other lanes use the reference model
    function automatic logic [OW-1:0] np_exp(input logic [15:0] p0, input logic [7:0] e0);
        logic [OW-1:0] v;
        for (int k = 0; k < LANES; k++) v[8*k +: 8] = (k == 0) ? e0 : model(p0 + 16'(k*24));
        return v;
    endfunction

    function automatic logic [DW-1:0] pool_beat(input int r, input int c, input int cols);
        logic [DW-1:0] v;
        int idx;
        idx = r*cols + c;
        for (int k = 0; k < 6; k++) v[16*k +: 16] = 16'(8*(idx + k));
        v[16*6 +: 16] = 16'h7000 + 16'(idx);
        v[16*7 +: 16] = 16'hFF00 - 16'(idx);
        return v;
    endfunction

    function automatic logic [OW-1:0] pool_exp(input int m);
        logic [OW-1:0] v;
        for (int k = 0; k < 6; k++) v[8*k +: 8] = 8'(m + k);
        v[8*6 +: 8] = 8'h7F;
        v[8*7 +: 8] = 8'h00;
        return v;
    endfunction

    task automatic start_tile(input int rows, input int cols, input logic pool);
        cfg_rows = 6'(rows);
        cfg_cols = 6'(cols);
        cfg_pool = pool;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        cfg_rows = 6'd0;
        cfg_cols = 6'd0;
        cfg_pool = 1'b0;
    endtask

    task automatic send_beat(input logic [DW-1:0] d);
        bit got;
        got      = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (!got) chk("beat_accept_timeout", 0, 1);
    endtask

    task automatic finish_tile(input int d0);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("done_once", 128'(done_cnt - d0), 1);
        chk("sb_drained", 128'(sb.size()), 0);
        @(posedge clk); #1;
    endtask

    logic [3:0][15:0] p35, p38, p40;
    logic [3:0][7:0]  e35, e38, e40;

    initial begin
        int d0;
        p35[0] = 16'h0028; p35[1] = 16'hFFF0; p35[2] = 16'h7FFF; p35[3] = 16'h0007;
        e35[0] = 8'h05;    e35[1] = 8'h00;    e35[2] = 8'h7F;    e35[3] = 8'h00;
        p38[0] = 16'h0100; p38[1] = 16'h0200; p38[2] = 16'h0300; p38[3] = 16'h0400;
        e38[0] = 8'h20;    e38[1] = 8'h40;    e38[2] = 8'h60;    e38[3] = 8'h7F;
        p40[0] = 16'h0010; p40[1] = 16'h0018; p40[2] = 16'h0020; p40[3] = 16'h0028;
        e40[0] = 8'h02;    e40[1] = 8'h03;    e40[2] = 8'h04;    e40[3] = 8'h05;

        rst = 1'b0; start = 1'b0; cfg_rows = '0; cfg_cols = '0; cfg_pool = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        #22;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // 2x2 no pool: negative, saturating and small psums
        for (int i = 0; i < 4; i++) sb.push_back(np_exp(p35[i], e35[i]));
        d0 = done_cnt;
        start_tile(2, 2, 1'b0);
        @(negedge clk);
        chk("busy_in_run", busy, 1);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) send_beat(np_beat(p35[i]));
        finish_tile(d0);

        // 4x4 pooled tile
        sb.push_back(pool_exp(5));
        sb.push_back(pool_exp(7));
        sb.push_back(pool_exp(13));
        sb.push_back(pool_exp(15));
        d0 = done_cnt;
        start_tile(4, 4, 1'b1);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) send_beat(pool_beat(r, c, 4));
        finish_tile(d0);

        // 3x5 pooled tile: odd trailing row and column produce nothing
        sb.push_back(pool_exp(6));
        sb.push_back(pool_exp(8));
        d0 = done_cnt;
        start_tile(3, 5, 1'b1);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 5; c++) send_beat(pool_beat(r, c, 5));
        @(negedge clk);
        chk("in_ready_after_last", in_ready, 0);
        @(posedge clk); #1;
        finish_tile(d0);

        // back-pressure: out_ready low for 5 cycles after the first output
        for (int i = 0; i < 4; i++) sb.push_back(np_exp(p38[i], e38[i]));
        d0 = done_cnt;
        start_tile(2, 2, 1'b0);
        fork
            begin
                for (int i = 0; i < 4; i++) send_beat(np_beat(p38[i]));
            end
            begin
                int n;
                n = 0;
                while (!out_valid && n < 50) begin
                    @(posedge clk); #1;
                    n++;
                end
                out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_out_valid", out_valid, 1);
                    chk("stall_out_data", out_data, np_exp(p38[0], e38[0]));
                    chk("stall_in_ready", in_ready, 0);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        finish_tile(d0);

        // zero-row tile completes immediately without accepting beats
        d0 = done_cnt;
        ir_cnt = 0;
        start_tile(0, 3, 1'b0);
        @(negedge clk);
        chk("zero_rows_done", done, 1);
        repeat (3) @(negedge clk);
        chk("zero_rows_done_once", 128'(done_cnt - d0), 1);
        chk("zero_rows_no_ready", 128'(ir_cnt), 0);
        @(posedge clk); #1;

        // start during RUN with different cfg must be ignored
        for (int i = 0; i < 4; i++) sb.push_back(np_exp(p35[i], e35[i]));
        d0 = done_cnt;
        start_tile(2, 2, 1'b0);
        send_beat(np_beat(p35[0]));
        start_tile(1, 1, 1'b1);
        for (int i = 1; i < 4; i++) send_beat(np_beat(p35[i]));
        finish_tile(d0);

        // mid-tile reset after 3 of 4 beats
        for (int i = 0; i < 3; i++) sb.push_back(np_exp(p40[i], e40[i]));
        d0 = done_cnt;
        start_tile(2, 2, 1'b0);
        for (int i = 0; i < 3; i++) send_beat(np_beat(p40[i]));
        rst = 1'b0;
        #2;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_out_data", out_data, 0);
        chk("abort_in_ready", in_ready, 0);
        chk("abort_busy", busy, 0);
        chk("abort_sb_left", 128'(sb.size()), 1);
        sb.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_no_done", 128'(done_cnt - d0), 0);
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) sb.push_back(np_exp(p40[i], e40[i]));
        d0 = done_cnt;
        start_tile(2, 2, 1'b0);
        for (int i = 0; i < 4; i++) send_beat(np_beat(p40[i]));
        finish_tile(d0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
        $finish;
    end
endmodule
